// File: rtl/risc_pkg.sv
// Shared definitions for the phase-1 RISC pipeline front end.
//   OP_NOP         : opcode presented to the control unit for a bubble
//   fetch_state_e  : fetch FSM states (REQ, WAIT, DRAIN)
//   *_DEF          : default address / instruction widths
package risc_pkg;

  localparam int unsigned ADDR_W_DEF  = 16;
  localparam int unsigned INSTR_W_DEF = 16;

  localparam logic [2:0] OP_NOP = 3'b000;

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_DRAIN
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry prefetch FIFO holding {pc, instr} pairs returned by instruction
// memory.
//   clk, rst   : clock, asynchronous active-low reset
//   push       : write push_data at the tail
//   push_data  : {pc, instr} of the returned word
//   pop        : drop the head entry
//   clear      : discard all entries (redirect); wins over push/pop
//   count      : number of valid entries (0..2)
//   head       : {pc, instr} of the oldest entry
module fetch_fifo
  import risc_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [ADDR_W+INSTR_W-1:0] push_data,
  input  logic                      pop,
  input  logic                      clear,
  output logic [1:0]                count,
  output logic [ADDR_W+INSTR_W-1:0] head
);

  logic [ADDR_W+INSTR_W-1:0] mem [2];
  logic                      rd_ptr;
  logic                      wr_ptr;
  logic [1:0]                cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign count = cnt;
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: generates the PC, fetches over a req/gnt/rvalid
// handshake with at most one request outstanding, buffers returned words in a
// two-entry FIFO and presents one registered instruction per cycle with its
// opcode field split out for the control unit.
//   clk, rst                : clock, asynchronous active-low reset
//   imem_req/addr           : fetch request and word address
//   imem_gnt                : request accepted this cycle
//   imem_rvalid/rdata       : returned instruction word
//   stall                   : downstream hold
//   flush/flush_pc          : redirect to flush_pc
//   instr/opCode/instr_pc   : registered instruction, opcode field, its PC
//   instr_valid             : output holds a real instruction
module fetch_unit
  import risc_pkg::*;
#(
  parameter int unsigned      ADDR_W   = ADDR_W_DEF,
  parameter int unsigned      INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  flush_pc,
  output logic [INSTR_W-1:0] instr,
  output logic [2:0]         opCode,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid
);

  fetch_state_e              state;
  logic [ADDR_W-1:0]         pc;
  logic [1:0]                fifo_count;
  logic [ADDR_W+INSTR_W-1:0] fifo_head;
  logic [ADDR_W-1:0]         head_pc;
  logic [INSTR_W-1:0]        head_instr;
  logic [2:0]                occ;
  logic                      pop;
  logic                      push;
  logic                      permitted;
  logic                      req;
  logic                      grant;
  logic                      stray_ok;

  assign head_pc    = fifo_head[ADDR_W+INSTR_W-1 -: ADDR_W];
  assign head_instr = fifo_head[INSTR_W-1:0];
  assign imem_addr  = pc;

  // Space accounting: an outstanding request already owns a FIFO slot, and a
  // pop this cycle frees one, so a new request is allowed while occ-pop < 2.
  always_comb begin
    pop       = !stall && !flush && (fifo_count != 2'd0);
    occ       = {1'b0, fifo_count} + {2'b0, (state == ST_WAIT)};
    permitted = occ < (3'd2 + {2'b0, pop});
    req       = 1'b0;
    unique case (state)
      ST_REQ:   req = permitted && !flush;
      // Back-to-back: the slot freed by the arriving response is reused.
      ST_WAIT:  req = imem_rvalid && permitted && !flush;
      default:  req = 1'b0;
    endcase
    imem_req = req && rst;
    grant    = imem_req && imem_gnt;
    push     = (state == ST_WAIT) && imem_rvalid && !flush;
  end

  fetch_fifo #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({pc - ADDR_W'(1), imem_rdata}),
    .pop       (pop),
    .clear     (flush),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // pc advances on grant, so the word arriving in WAIT belongs to pc-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_REQ;
      pc       <= RESET_PC;
      stray_ok <= 1'b1;
    end else begin
      if (grant) begin
        stray_ok <= 1'b0;
      end
      if (flush) begin
        pc <= flush_pc;
      end else if (grant) begin
        pc <= pc + ADDR_W'(1);
      end
      unique case (state)
        ST_REQ: begin
          if (grant) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (flush) begin
            state <= imem_rvalid ? ST_REQ : ST_DRAIN;
          end else if (imem_rvalid) begin
            state <= grant ? ST_WAIT : ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (imem_rvalid) state <= ST_REQ;
        end
        default: state <= ST_REQ;
      endcase
    end
  end

  // A response arriving with nothing outstanding is only legitimate as the
  // orphan of a request cut off by reset, before the first new grant.
  always_ff @(posedge clk) begin
    if (rst && (state == ST_REQ) && imem_rvalid) begin
      assert (stray_ok);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr       <= '0;
      opCode      <= OP_NOP;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (flush) begin
      instr       <= '0;
      opCode      <= OP_NOP;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (stall) begin
      instr       <= instr;
      opCode      <= opCode;
      instr_pc    <= instr_pc;
      instr_valid <= instr_valid;
    end else if (pop) begin
      instr       <= head_instr;
      opCode      <= head_instr[INSTR_W-1 -: 3];
      instr_pc    <= head_pc;
      instr_valid <= 1'b1;
    end else begin
      instr       <= '0;
      opCode      <= OP_NOP;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory responder with configurable
// latency and grant behaviour, plus an in-order scoreboard of expected PCs.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic [15:0] flush_pc;
  logic [15:0] instr;
  logic [2:0]  opCode;
  logic [15:0] instr_pc;
  logic        instr_valid;

  // Second instance exercising PC wrap from RESET_PC = 16'hFFFF.
  logic        b_req;
  logic [15:0] b_addr;
  logic        b_rvalid;
  logic [15:0] b_rdata;
  logic        b_zero;
  logic [15:0] b_zero_pc;
  logic [15:0] b_instr;
  logic [2:0]  b_op;
  logic [15:0] b_pc;
  logic        b_valid;

  fetch_unit #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .flush(flush), .flush_pc(flush_pc), .instr(instr),
    .opCode(opCode), .instr_pc(instr_pc), .instr_valid(instr_valid)
  );

  fetch_unit #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'hFFFF)) dut_wrap (
    .clk(clk), .rst(rst), .imem_req(b_req), .imem_addr(b_addr),
    .imem_gnt(1'b1), .imem_rvalid(b_rvalid), .imem_rdata(b_rdata),
    .stall(b_zero), .flush(b_zero), .flush_pc(b_zero_pc), .instr(b_instr),
    .opCode(b_op), .instr_pc(b_pc), .instr_valid(b_valid)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc;
  int unsigned consumed;

  // memory responder
  bit          pend;
  bit          pend_orphan;
  logic [15:0] pend_addr;
  int unsigned pend_due;
  int unsigned lat_lo;
  int unsigned lat_hi;
  int          gnt_mode;        // 0 always, 1 random, 2 never

  // reference model
  bit          sb_on;
  logic [15:0] exp_pc;
  logic [15:0] fetch_pc;
  logic [15:0] p_instr, p_pc;
  logic [2:0]  p_op;
  logic        p_valid;
  bit          p_stall, p_flush;

  // last sampled values
  logic        s_req, s_valid;
  logic [15:0] s_addr, s_pc, s_instr;
  logic [2:0]  s_op;
  bit          s_grant, s_rvalid;

  logic [15:0] wrap_q[$];
  bit          wrap_resp;
  logic [15:0] wrap_addr;

  function automatic logic [15:0] memf(input logic [15:0] a);
    logic [15:0] t;
    t = a + 16'd1;
    return t * 16'h2001;
  endfunction

  function automatic logic [2:0] op_of(input logic [15:0] a);
    logic [15:0] w;
    w = memf(a);
    return w[15:13];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic init_model();
    cyc      = 0;
    exp_pc   = 16'h0000;
    fetch_pc = 16'h0000;
    p_instr  = '0; p_pc = '0; p_op = '0; p_valid = 1'b0;
    p_stall  = 1'b0;
    p_flush  = 1'b0;
    sb_on    = 1'b1;
  endtask

  // One clock cycle; entered and left 1 time unit after a rising edge.
  task automatic step();
    imem_rvalid = pend && (cyc >= pend_due);
    imem_rdata  = imem_rvalid ? memf(pend_addr) : 16'($urandom);
    case (gnt_mode)
      0:       imem_gnt = 1'b1;
      1:       imem_gnt = 1'($urandom_range(0, 1));
      default: imem_gnt = 1'b0;
    endcase
    b_rvalid = wrap_resp;
    b_rdata  = memf(wrap_addr);

    @(negedge clk);
    s_req = imem_req;  s_addr = imem_addr;
    s_valid = instr_valid; s_pc = instr_pc; s_instr = instr; s_op = opCode;
    s_grant = imem_req && imem_gnt;
    s_rvalid = imem_rvalid;

    if (sb_on) begin
      if (p_flush) begin
        chk("flush_bubble_valid", s_valid, 0);
        chk("flush_bubble_op", s_op, 0);
        chk("flush_bubble_instr", s_instr, 0);
      end else if (p_stall) begin
        chk("stall_hold", {s_valid, s_op, s_instr}, {p_valid, p_op, p_instr});
        chk("stall_hold_pc", s_pc, p_pc);
      end else if (s_valid) begin
        chk("instr_pc", s_pc, exp_pc);
        chk("instr", s_instr, memf(exp_pc));
        chk("opcode", s_op, op_of(exp_pc));
        exp_pc = exp_pc + 16'd1;
        consumed++;
      end else begin
        chk("bubble_instr", s_instr, 0);
        chk("bubble_op", s_op, 0);
      end
      if (flush) chk("no_req_on_flush", s_req, 0);
      if (s_req && !pend_orphan) chk("one_outstanding", pend && !imem_rvalid, 0);
      if (s_grant) begin
        chk("fetch_addr", s_addr, fetch_pc);
        fetch_pc = fetch_pc + 16'd1;
      end
    end

    if (imem_rvalid) begin
      pend = 1'b0;
      pend_orphan = 1'b0;
    end
    if (s_grant) begin
      pend      = 1'b1;
      pend_addr = s_addr;
      pend_due  = cyc + $urandom_range(lat_lo, lat_hi);
    end

    if (b_req) begin
      if (wrap_q.size() < 3) wrap_q.push_back(b_addr);
      wrap_addr = b_addr;
    end
    wrap_resp = b_req;

    if (flush) begin
      exp_pc   = flush_pc;
      fetch_pc = flush_pc;
    end
    p_instr = s_instr; p_pc = s_pc; p_op = s_op; p_valid = s_valid;
    p_stall = stall;
    p_flush = flush;

    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          first_c;
    int          nvalid;
    int unsigned c;
    bit          got;
    logic [15:0] fv_instr, fv_pc, rpc;
    logic [2:0]  fv_op;

    rst = 1'b0;
    stall = 1'b0; flush = 1'b0; flush_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    b_rvalid = 1'b0; b_rdata = '0; b_zero = 1'b0; b_zero_pc = '0;
    pend = 1'b0; pend_orphan = 1'b0; pend_addr = '0; pend_due = 0;
    lat_lo = 1; lat_hi = 1; gnt_mode = 0;
    wrap_resp = 1'b0; wrap_addr = '0; consumed = 0;
    fv_instr = '0; fv_pc = '0; fv_op = '0;
    sb_on = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #2;
    chk("reset_instr", instr, 0);
    chk("reset_op", opCode, 0);
    chk("reset_instr_pc", instr_pc, 0);
    chk("reset_valid", instr_valid, 0);
    chk("reset_req", imem_req, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    init_model();

    // straight-line fetch, 1-cycle memory
    first_c = -1;
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      c = cyc;
      step();
      if (s_valid) begin
        nvalid++;
        if (first_c < 0) begin
          first_c = int'(c);
          fv_instr = s_instr; fv_op = s_op; fv_pc = s_pc;
        end
      end
    end
    // registered at the end of cycle 2, visible during cycle 3
    chk("first_valid_cycle", first_c, 3);
    chk("first_instr", fv_instr, 16'h2001);
    chk("first_opcode", fv_op, 3'b001);
    chk("first_pc", fv_pc, 16'h0000);
    chk("throughput", nvalid, 5);

    // stall mid-stream
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i >= 1) chk("req_drop_under_stall", s_req, 0);
    end
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("no_gap_after_stall", s_valid, 1);
    end

    // 3-cycle memory, flush while waiting
    lat_lo = 3; lat_hi = 3;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = s_grant;
    end
    chk("grant_before_flush", got, 1);
    flush = 1'b1; flush_pc = 16'h0040;
    step();
    flush = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      chk("drain_no_req", s_req, 0);
      got = s_rvalid;
    end
    chk("late_response_seen", got, 1);
    step();
    chk("req_after_drain", s_req, 1);
    chk("addr_after_drain", s_addr, 16'h0040);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = s_valid;
    end
    chk("valid_after_flush", got, 1);
    chk("pc_after_flush", s_pc, 16'h0040);
    chk("op_after_flush", s_op, 3'b001);

    // flush and stall together with a valid output
    lat_lo = 1; lat_hi = 1;
    repeat (8) step();
    rpc = 16'($urandom);
    stall = 1'b1; flush = 1'b1; flush_pc = rpc;
    step();
    chk("valid_before_flush_stall", s_valid, 1);
    stall = 1'b0; flush = 1'b0;
    step();
    chk("fs_valid", s_valid, 0);
    chk("fs_op", s_op, 0);
    chk("fs_req", s_req, 1);
    chk("fs_addr", s_addr, rpc);
    step();
    chk("fs_fifo_emptied", s_valid, 0);

    // randomized traffic
    gnt_mode = 1; lat_lo = 1; lat_hi = 3;
    consumed = 0;
    for (int i = 0; i < 600; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 19) == 0);
      flush_pc = 16'($urandom);
      step();
    end
    stall = 1'b0; flush = 1'b0;
    chk("random_progress", consumed > 50, 1);

    // settle into a steady 1-cycle stream
    gnt_mode = 0; lat_lo = 1; lat_hi = 1;
    repeat (10) step();

    // reset while a response is pending
    chk("pending_before_reset", pend, 1);
    chk("valid_before_reset", instr_valid, 1);
    imem_rvalid = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("async_reset_valid", instr_valid, 0);
    chk("async_reset_instr", instr, 0);
    chk("async_reset_op", opCode, 0);
    chk("async_reset_pc", instr_pc, 0);
    chk("async_reset_req", imem_req, 0);
    sb_on = 1'b0;
    pend_orphan = 1'b1;
    wrap_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    init_model();
    pend_due = 1;
    gnt_mode = 2;
    step();
    chk("first_req_after_reset", s_req, 1);
    chk("first_addr_after_reset", s_addr, 16'h0000);
    step();
    chk("req_during_stray", s_req, 1);
    chk("addr_during_stray", s_addr, 16'h0000);
    gnt_mode = 0;
    consumed = 0;
    repeat (8) step();
    chk("progress_after_reset", consumed > 3, 1);

    // PC wrap instance
    chk("wrap_count", wrap_q.size() >= 3, 1);
    if (wrap_q.size() >= 3) begin
      chk("wrap_addr0", wrap_q[0], 16'hFFFF);
      chk("wrap_addr1", wrap_q[1], 16'h0000);
      chk("wrap_addr2", wrap_q[2], 16'h0001);
    end
    chk("wrap_valid", b_valid, 1);
    chk("wrap_instr", b_instr, memf(b_pc));
    chk("wrap_op", b_op, op_of(b_pc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the control unit in the phase-1 RISC pipeline.
- Generates the PC and issues requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a 2-entry prefetch FIFO and presents one registered instruction per cycle, with its opCode field split out for the control unit.
- Supports a downstream stall and a redirect (flush) from later stages.

Parameters:
- ADDR_W, 16, PC / instruction-memory word-address width.
- INSTR_W, 16, instruction width; opCode = instr[INSTR_W-1:INSTR_W-3].
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  word address; valid while imem_req.
- imem_gnt  in  1  memory accepts the request this cycle; meaningful only with imem_req.
- imem_rvalid  in  1  read data valid; at most one response per granted request.
- imem_rdata  in  INSTR_W  read data.
- stall  in  1  downstream hold.
- flush  in  1  redirect.
- flush_pc  in  ADDR_W  redirect target.
- instr  out  INSTR_W  registered instruction.
- opCode  out  3  registered; drives the control unit opCode input.
- instr_pc  out  ADDR_W  PC of instr.
- instr_valid  out  1  output holds a real instruction.

Behaviour:
- Reset (rst low, async):
  - pc=RESET_PC, state=REQ, FIFO empty.
  - instr=0, opCode=3'b000 (NOP bubble), instr_pc=0, instr_valid=0.
  - imem_req forced 0 while rst low.
- Word addressing: pc increments by 1 on each grant, mod 2^ADDR_W (0xFFFF wraps to 0x0000).
- Outstanding requests: at most one.
- Space rule:
  - occ = fifo_count + (state==WAIT).
  - pop = !stall & !flush & fifo_count>0.
  - Request permitted only if occ - pop < 2.
- FSM REQ:
  - imem_req = permitted & !flush; imem_addr = pc.
  - On gnt: pc <= pc+1, go to WAIT.
- FSM WAIT:
  - On rvalid: push imem_rdata with its PC into the FIFO.
  - In the same cycle, imem_req may assert (same space rule); gnt moves back to WAIT, otherwise go to REQ.
- FSM DRAIN:
  - imem_req=0.
  - On rvalid: discard data, go to REQ.
- Output register, evaluated each edge with priority flush > stall > pop > bubble:
  - flush: load bubble (instr=0, opCode=000, instr_valid=0).
  - stall: hold all outputs.
  - pop: load FIFO head, instr_valid=1.
  - FIFO empty and !stall: load bubble.
- Flush handling (pc <= flush_pc, FIFO cleared):
  - In REQ: no request that cycle, stay in REQ.
  - In WAIT without rvalid: go to DRAIN.
  - In WAIT with rvalid: discard data, go to REQ.
  - In DRAIN: stay in DRAIN, or go to REQ if rvalid.
- Latency, 1-cycle memory: gnt in cycle N, rvalid N+1, FIFO write at end of N+1, instr_valid at end of N+2. Steady-state throughput 1 instr/cycle.
- Full FIFO plus stall: requests stop; nothing is lost or duplicated.
- Stray rvalid in REQ is ignored; simulation assertion flags it.
- Reset mid-WAIT: pending response is forgotten; a later stray rvalid is ignored.

Decomposition:
- Shared package risc_pkg holds:
  - NOP opcode 3'b000.
  - FSM state encoding (REQ, WAIT, DRAIN).
  - Default ADDR_W and INSTR_W.
- Sub-module fetch_fifo: 2-entry FIFO.
  - Each entry is {pc, instr}.
  - Ports: push, pop, clear, count, head.
  - Same clk and rst.

Test Plan:
- Straight-line fetch: mem[0..3] = 16'h2001, 16'h4002, 16'h6003, 16'h8004, 1-cycle memory, gnt always 1, rst released at cycle 0 -> instr_valid first at end of cycle 2 with instr_pc=0, instr=16'h2001, opCode=3'b001; then one instruction per cycle, opCodes 010, 011, 100.
- Stall for 4 cycles mid-stream -> outputs frozen; imem_req drops once 2 entries are buffered; after release, remaining instructions appear in PC order with no gaps or duplicates.
- 3-cycle memory latency, flush with flush_pc=16'h0040 while in WAIT -> state DRAIN; late response discarded; next instr_valid shows instr_pc=16'h0040; opCode=000 while invalid.
- flush and stall in the same cycle with a valid output -> next cycle instr_valid=0, opCode=000, FIFO empty, next request address = flush_pc.
- RESET_PC=16'hFFFF -> imem_addr sequence FFFF, 0000, 0001.
- Assert rst low mid-WAIT -> outputs clear immediately; stray rvalid after release ignored; first request after release is to RESET_PC.
